money_bank: RTL and testbench
=============================

MONEY_BANK -- requirements
Module: money_bank

Interface
REQ-001 Port clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 Port rst_n, input, 1: reset, synchronous, active-low.
REQ-003 Port mode, input, 2: 00 idle, 01 customer insert/buy, 10 owner collect, 11 reserved (treated as 00).
REQ-004 Port coin_valid, input, 1: one-cycle strobe; coin present on coin_value.
REQ-005 Port coin_value, input, 2: 00 = 1 unit, 01 = 2 units, 10 = 5 units, 11 = invalid coin.
REQ-006 Port buy_req, input, 1: one-cycle strobe requesting purchase at price.
REQ-007 Port price, input, 4: item price in units, sampled on buy_req.
REQ-008 Port machine_money, output, 4: owner's banked total; feeds the owner-collect stage.
REQ-009 Port credit, output, 4: current customer credit.
REQ-010 Port vend, output, 1: one-cycle pulse, item released.
REQ-011 Port change, output, 4, and change_valid, output, 1: change amount, valid for exactly one cycle.
REQ-012 Port coin_reject, output, 1: one-cycle pulse, inserted coin returned unaccepted.
REQ-013 Port busy, output, 1: high in any state other than IDLE/CREDIT.

Function
REQ-014 FSM states: IDLE, CREDIT, VEND, CHANGE, COLLECT.
REQ-015 IDLE: accepted coin -> CREDIT; mode==10 -> COLLECT; buy_req ignored.
REQ-016 CREDIT: coins accumulate; buy_req with price<=credit -> VEND; buy_req with price>credit ignored, state held.
REQ-017 Coin accepted only if mode==01, state IDLE/CREDIT, coin_value!=11, and credit+value<=15; else coin_reject pulses the next cycle.
REQ-018 Accepted coin updates credit the next cycle (latency 1).
REQ-019 VEND (1 cycle): vend=1; machine_money += price, saturating at 15; credit -= price; -> CHANGE if remaining credit>0, else IDLE.
REQ-020 CHANGE (1 cycle): change=remaining credit, change_valid=1, credit cleared -> IDLE.
REQ-021 Leaving mode 01 while in CREDIT: credit returned via a CHANGE cycle, then IDLE.
REQ-022 COLLECT: machine_money held for exactly one cycle so the downstream collector samples it, then cleared to 0 -> IDLE; coins arriving in COLLECT are rejected.
REQ-023 coin_valid and buy_req in the same CREDIT cycle: buy is evaluated against pre-coin credit; coin is accepted and included in the change returned.
REQ-024 change holds 0 whenever change_valid=0.

Reset
REQ-025 rst_n=0 at a clock edge: state IDLE; machine_money, credit, change = 0; vend, change_valid, coin_reject, busy = 0.
REQ-026 Reset mid-VEND/CHANGE aborts: no vend, change or reject pulse issued; credit lost.

Configuration
REQ-027 Macro MONEY_BANK_REFUND_EN: defined -> REQ-021 refund behaviour; undefined -> credit retained across a mode change and returned only after a purchase.

Structure
REQ-028 Shared package: FSM state enum, mode encodings (MODE_IDLE/MODE_CUSTOMER/MODE_OWNER), coin_value encodings, MONEY_MAX=15.
REQ-029 Sub-module coin_decoder (combinational): coin_value -> unit value plus invalid flag.

Verification
REQ-030 Reset, then mode=01, coins 5,5,2 -> credit 5,10,12, no reject.
REQ-031 credit=12, buy_req with price=7 -> vend pulse, machine_money=7, next cycle change=5 with change_valid, credit=0.
REQ-032 credit=14, 2-unit coin -> coin_reject pulse, credit stays 14; coin_value=11 -> reject.
REQ-033 machine_money=9, mode=10 -> one cycle at 9, then 0, state IDLE; coin during COLLECT -> reject.
REQ-034 credit=3, buy_req with price=5 -> no vend, credit 3; mode 01->00 -> change=3 (with macro), credit retained (without).
REQ-035 rst_n low during VEND -> all outputs 0 next cycle, no vend pulse.

Source files
------------

// File: rtl/money_bank_pkg.sv
// Shared types and constants for the money_bank vending slice.
// FSM state enum, mode/coin encodings and the saturating money helper.
package money_bank_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_CHANGE,
        ST_COLLECT
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'b00,
        MODE_CUSTOMER = 2'b01,
        MODE_OWNER    = 2'b10,
        MODE_RESERVED = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        COIN_1   = 2'b00,
        COIN_2   = 2'b01,
        COIN_5   = 2'b10,
        COIN_BAD = 2'b11
    } coin_t;

    localparam logic [3:0] MONEY_MAX = 4'd15;

    function automatic logic [3:0] sat_add(input logic [3:0] a, input logic [3:0] b);
        logic [4:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, MONEY_MAX}) ? MONEY_MAX : sum[3:0];
    endfunction

endpackage

// File: rtl/money_bank_if.sv
// Customer/owner bus of money_bank: stimulus side drives through master,
// the bank itself attaches through slave.
interface money_bank_if;

    logic [1:0] mode;
    logic       coin_valid;
    logic [1:0] coin_value;
    logic       buy_req;
    logic [3:0] price;

    logic [3:0] machine_money;
    logic [3:0] credit;
    logic       vend;
    logic [3:0] change;
    logic       change_valid;
    logic       coin_reject;
    logic       busy;

    modport master (
        output mode, coin_valid, coin_value, buy_req, price,
        input  machine_money, credit, vend, change, change_valid, coin_reject, busy
    );

    modport slave (
        input  mode, coin_valid, coin_value, buy_req, price,
        output machine_money, credit, vend, change, change_valid, coin_reject, busy
    );

endinterface

// File: rtl/money_bank_coin_decoder.sv
// Combinational coin decoder: coin_value code to unit value plus invalid flag.
module coin_decoder
    import money_bank_pkg::*;
(
    input  logic [1:0] coin_value,
    output logic [3:0] units,
    output logic       invalid
);

    always_comb begin
        units   = '0;
        invalid = 1'b0;
        unique case (coin_t'(coin_value))
            COIN_1:   units = 4'd1;
            COIN_2:   units = 4'd2;
            COIN_5:   units = 4'd5;
            COIN_BAD: invalid = 1'b1;
            default:  invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/money_bank.sv
// Coin-operated bank: credit accumulation, vend/change and owner collection.
// MONEY_BANK_REFUND_EN: refund credit via a CHANGE cycle when mode leaves customer.
module money_bank
    import money_bank_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    money_bank_if.slave  bus
);

    state_t     state;
    logic [3:0] machine_money_q;
    logic [3:0] credit_q;
    logic [3:0] change_q;
    logic       vend_q;
    logic       change_valid_q;
    logic       coin_reject_q;
    logic       busy_q;

    logic [3:0] coin_units;
    logic       coin_invalid;
    logic       accepting;
    logic [4:0] credit_sum;
    logic       coin_accept;
    logic [3:0] credit_in;
    logic       buy_ok;

    coin_decoder u_coin_decoder (
        .coin_value (bus.coin_value),
        .units      (coin_units),
        .invalid    (coin_invalid)
    );

    assign accepting   = (state == ST_IDLE) || (state == ST_CREDIT);
    assign credit_sum  = {1'b0, credit_q} + {1'b0, coin_units};
    assign coin_accept = bus.coin_valid && (bus.mode == MODE_CUSTOMER) && accepting &&
                         !coin_invalid && (credit_sum <= {1'b0, MONEY_MAX});
    assign credit_in   = coin_accept ? credit_sum[3:0] : credit_q;
    // Purchase is judged on pre-coin credit; a same-cycle coin still lands in credit_in.
    assign buy_ok      = (state == ST_CREDIT) && bus.buy_req && (bus.price <= credit_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            machine_money_q <= '0;
            credit_q        <= '0;
            change_q        <= '0;
            vend_q          <= 1'b0;
            change_valid_q  <= 1'b0;
            coin_reject_q   <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            vend_q         <= 1'b0;
            change_valid_q <= 1'b0;
            change_q       <= '0;
            coin_reject_q  <= bus.coin_valid && !coin_accept;
            unique case (state)
                ST_IDLE: begin
                    if (coin_accept) begin
                        credit_q <= credit_in;
                        state    <= ST_CREDIT;
                    end else if (bus.mode == MODE_OWNER) begin
                        state  <= ST_COLLECT;
                        busy_q <= 1'b1;
                    end
                end
                ST_CREDIT: begin
                    if (buy_ok) begin
                        state           <= ST_VEND;
                        vend_q          <= 1'b1;
                        busy_q          <= 1'b1;
                        credit_q        <= credit_in - bus.price;
                        machine_money_q <= sat_add(machine_money_q, bus.price);
                    end
`ifdef MONEY_BANK_REFUND_EN
                    else if (bus.mode != MODE_CUSTOMER) begin
                        state          <= ST_CHANGE;
                        change_q       <= credit_q;
                        change_valid_q <= 1'b1;
                        credit_q       <= '0;
                        busy_q         <= 1'b1;
                    end
`endif
                    else begin
                        credit_q <= credit_in;
                    end
                end
                ST_VEND: begin
                    if (credit_q != '0) begin
                        state          <= ST_CHANGE;
                        change_q       <= credit_q;
                        change_valid_q <= 1'b1;
                        credit_q       <= '0;
                    end else begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                ST_CHANGE: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
                ST_COLLECT: begin
                    machine_money_q <= '0;
                    state           <= ST_IDLE;
                    busy_q          <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.machine_money = machine_money_q;
    assign bus.credit        = credit_q;
    assign bus.change        = change_q;
    assign bus.vend          = vend_q;
    assign bus.change_valid  = change_valid_q;
    assign bus.coin_reject   = coin_reject_q;
    assign bus.busy          = busy_q;

endmodule

// File: tb/tb_money_bank.sv
// Scoreboard bench for money_bank: a ledger model predicts each cycle's outputs,
// a monitor pops and compares them after every clock edge.
module tb_money_bank;
    import money_bank_pkg::*;

    typedef struct packed {
        logic [3:0] mm;
        logic [3:0] credit;
        logic [3:0] change;
        logic       vend;
        logic       cv;
        logic       rej;
        logic       busy;
    } snap_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    money_bank_if bus();

    money_bank dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    snap_t       exp_q[$];
    snap_t       plan[$];
    snap_t       mon_e;
    int unsigned m_credit = 0;
    int unsigned m_bank = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic int unsigned coin_worth(input logic [1:0] v);
        case (v)
            2'b00:   return 1;
            2'b01:   return 2;
            2'b10:   return 5;
            default: return 0;
        endcase
    endfunction

    function automatic snap_t payout(input int unsigned c, input int unsigned bank);
        snap_t s;
        s = '0;
        s.mm = bank[3:0];
        s.change = c[3:0];
        s.cv = 1'b1;
        s.busy = 1'b1;
        return s;
    endfunction

    function automatic snap_t rest(input int unsigned bank);
        snap_t s;
        s = '0;
        s.mm = bank[3:0];
        return s;
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One cycle of stimulus plus the ledger's prediction of the outputs after the next edge.
    task automatic step(input logic r, input logic [1:0] md, input logic cvld,
                        input logic [1:0] cval, input logic buy, input logic [3:0] pr);
        snap_t       e;
        int unsigned val;
        bit          acc;
        @(negedge clk);
        rst_n          = r;
        bus.mode       = md;
        bus.coin_valid = cvld;
        bus.coin_value = cval;
        bus.buy_req    = buy;
        bus.price      = pr;
        e = '0;
        if (!r) begin
            plan.delete();
            m_credit = 0;
            m_bank = 0;
        end else if (plan.size() > 0) begin
            e = plan.pop_front();
            e.rej = cvld;
        end else begin
            val = coin_worth(cval);
            acc = cvld && (md == 2'b01) && (cval != 2'b11) && (m_credit + val <= 15);
            if (m_credit > 0 && buy && pr <= m_credit) begin
                m_bank = (m_bank + pr > 15) ? 15 : m_bank + pr;
                m_credit = m_credit + (acc ? val : 0) - pr;
                e.vend = 1'b1;
                e.busy = 1'b1;
                e.credit = m_credit[3:0];
                e.mm = m_bank[3:0];
                if (m_credit > 0) plan.push_back(payout(m_credit, m_bank));
                plan.push_back(rest(m_bank));
                m_credit = 0;
            end
`ifdef MONEY_BANK_REFUND_EN
            else if (m_credit > 0 && md != 2'b01) begin
                e = payout(m_credit, m_bank);
                plan.push_back(rest(m_bank));
                m_credit = 0;
            end
`endif
            else if (m_credit == 0 && md == 2'b10) begin
                e.busy = 1'b1;
                e.mm = m_bank[3:0];
                m_bank = 0;
                plan.push_back(rest(m_bank));
            end else begin
                if (acc) m_credit += val;
                e.credit = m_credit[3:0];
                e.mm = m_bank[3:0];
            end
            e.rej = cvld && !acc;
        end
        exp_q.push_back(e);
    endtask

    task automatic idle_steps(input int n, input logic [1:0] md);
        for (int i = 0; i < n; i++) step(1'b1, md, 1'b0, 2'b00, 1'b0, 4'd0);
    endtask

    always @(posedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("machine_money", bus.machine_money, mon_e.mm);
            check("credit", bus.credit, mon_e.credit);
            check("change", bus.change, mon_e.change);
            check("vend", bus.vend, mon_e.vend);
            check("change_valid", bus.change_valid, mon_e.cv);
            check("coin_reject", bus.coin_reject, mon_e.rej);
            check("busy", bus.busy, mon_e.busy);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [1:0] md;
        logic       cvld;
        logic       buy;
        int unsigned pick;
        bus.mode = 2'b00;
        bus.coin_valid = 1'b0;
        bus.coin_value = 2'b00;
        bus.buy_req = 1'b0;
        bus.price = 4'd0;

        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0);
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0);

        // coins 5,5,2 then buy 7 with change 5
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 4'd7);
        idle_steps(3, 2'b01);

        // fill to 14, overflow coin and bad coin rejected
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b11, 1'b0, 4'd0);
        idle_steps(1, 2'b01);

        // bank 9 then owner collect with a coin arriving during collect
        step(1'b0, 2'b00, 1'b0, 2'b00, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 4'd9);
        idle_steps(3, 2'b00);
        step(1'b1, 2'b10, 1'b0, 2'b00, 1'b0, 4'd0);
        step(1'b1, 2'b10, 1'b1, 2'b00, 1'b0, 4'd0);
        idle_steps(2, 2'b00);

        // credit 3, too-expensive buy ignored, then leave customer mode
        step(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b00, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 4'd5);
        idle_steps(3, 2'b00);
        step(1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 4'd3);
        idle_steps(3, 2'b01);

        // same-cycle coin and buy: buy on pre-coin credit, coin lands in change
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b1, 2'b01, 1'b1, 4'd5);
        idle_steps(3, 2'b01);

        // reset during the vend cycle
        step(1'b1, 2'b01, 1'b1, 2'b10, 1'b0, 4'd0);
        step(1'b1, 2'b01, 1'b0, 2'b00, 1'b1, 4'd2);
        step(1'b0, 2'b01, 1'b0, 2'b00, 1'b0, 4'd0);
        idle_steps(2, 2'b01);

        for (int n = 0; n < 3000; n++) begin
            pick = $urandom_range(0, 9);
            md = (pick <= 5) ? 2'b01 : (pick <= 7) ? 2'b00 : (pick == 8) ? 2'b10 : 2'b11;
            cvld = ($urandom_range(0, 1) == 1);
            buy = (md == 2'b01) && ($urandom_range(0, 3) == 0);
            step(($urandom_range(0, 149) != 0), md, cvld, 2'($urandom_range(0, 3)),
                 buy, 4'($urandom_range(0, 15)));
        end

        idle_steps(4, 2'b00);
        repeat (2) @(posedge clk);
        #3;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
